// File: rtl/msdap_pkg.sv
// Shared types and defaults for the MSDAP serial input path.
`timescale 1ns/1ps
package msdap_pkg;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_e;

  localparam int MSDAP_WORD_W   = 16;
  localparam int MSDAP_NUM_CH   = 2;
  localparam int MSDAP_ZERO_RUN = 800;

  // Bits needed to hold every value from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/msdap_sync_edge.sv
// Multi-stage synchroniser for an asynchronous bus plus a registered rising-edge
// strobe on edge_in; q is registered alongside the strobe so both stay aligned.
`timescale 1ns/1ps
module msdap_sync_edge #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             edge_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rise
);

  logic [STAGES-1:0][WIDTH:0] sync_reg;
  logic                       edge_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg   <= '0;
      edge_d_reg <= 1'b0;
      q          <= '0;
      rise       <= 1'b0;
    end else begin
      sync_reg[0] <= {d, edge_in};
      for (int i = 1; i < STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      edge_d_reg <= sync_reg[STAGES-1][0];
      rise       <= sync_reg[STAGES-1][0] & ~edge_d_reg;
      q          <= sync_reg[STAGES-1][WIDTH:1];
    end
  end

endmodule

// File: rtl/msdap_frame_rx.sv
// Parametrised multi-channel serial frame receiver with frame-error and
// all-zero run detection, running entirely in the SCLK domain.
`timescale 1ns/1ps
module msdap_frame_rx
  import msdap_pkg::*;
#(
  parameter int NUM_CH      = MSDAP_NUM_CH,
  parameter int WORD_W      = MSDAP_WORD_W,
  parameter int SYNC_STAGES = 2,
  parameter int ZERO_RUN    = MSDAP_ZERO_RUN,
  parameter int MSB_FIRST   = 1
) (
  input  logic                     SCLK,
  input  logic                     Reset_n,
  input  logic                     DCLK,
  input  logic                     Frame,
  input  logic [NUM_CH-1:0]        Din,
  input  logic                     Enable,
  output logic [NUM_CH*WORD_W-1:0] Word_out,
  output logic                     Word_valid,
  output logic                     Frame_err,
  output logic                     All_zero,
  output logic                     Busy
);

  localparam int CNT_W = cnt_width(WORD_W);
  localparam int ZC_W  = cnt_width(ZERO_RUN);

  logic [NUM_CH:0]                bus_q;
  logic                           strobe;
  logic                           frame_s;
  logic [NUM_CH-1:0]              din_s;

  rx_state_e                      state_reg, state_next;
  logic [CNT_W-1:0]               bit_cnt_reg, bit_cnt_next;
  logic [ZC_W-1:0]                zero_cnt_reg, zero_cnt_next;
  logic [NUM_CH-1:0][WORD_W-1:0]  shift_reg, shift_next;
  logic [NUM_CH-1:0][WORD_W-1:0]  shifted, first_bit;
  logic [NUM_CH*WORD_W-1:0]       word_next;
  logic                           valid_next, err_next, all_zero_next;

  msdap_sync_edge #(
    .WIDTH  (NUM_CH + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (SCLK),
    .rst_n   (Reset_n),
    .edge_in (DCLK),
    .d       ({Din, Frame}),
    .q       (bus_q),
    .rise    (strobe)
  );

  assign frame_s = bus_q[0];
  assign din_s   = bus_q[NUM_CH:1];
  assign Busy    = (state_reg == RX_RECV);

  // Shift direction is chosen so a completed word always lands in natural order.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    if (MSB_FIRST != 0) begin : g_msb
      assign shifted[gi]   = (shift_reg[gi] << 1) | WORD_W'(din_s[gi]);
      assign first_bit[gi] = WORD_W'(din_s[gi]);
    end else begin : g_lsb
      assign shifted[gi]   = (shift_reg[gi] >> 1) | (WORD_W'(din_s[gi]) << (WORD_W - 1));
      assign first_bit[gi] = WORD_W'(din_s[gi]) << (WORD_W - 1);
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    zero_cnt_next = zero_cnt_reg;
    word_next     = Word_out;
    valid_next    = 1'b0;
    err_next      = 1'b0;
    all_zero_next = All_zero;
    if (!Enable) begin
      state_next   = RX_IDLE;
      bit_cnt_next = '0;
    end else begin
      case (state_reg)
        RX_IDLE: begin
          if (strobe && frame_s) begin
            shift_next   = first_bit;
            bit_cnt_next = CNT_W'(1);
            state_next   = RX_RECV;
          end
        end
        RX_RECV: begin
          if (bit_cnt_reg == CNT_W'(WORD_W)) begin
            valid_next   = 1'b1;
            word_next    = shift_reg;
            state_next   = RX_IDLE;
            bit_cnt_next = '0;
            if (shift_reg == '0) begin
              if (zero_cnt_reg != ZC_W'(ZERO_RUN)) zero_cnt_next = zero_cnt_reg + ZC_W'(1);
            end else begin
              zero_cnt_next = '0;
            end
            all_zero_next = (zero_cnt_next == ZC_W'(ZERO_RUN));
          end else if (strobe) begin
            if (frame_s) begin
              // Early Frame: drop the partial word and treat this bit as a new start.
              err_next     = 1'b1;
              shift_next   = first_bit;
              bit_cnt_next = CNT_W'(1);
            end else begin
              shift_next   = shifted;
              bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            end
          end
        end
        default: state_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge SCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= RX_IDLE;
      bit_cnt_reg  <= '0;
      zero_cnt_reg <= '0;
      shift_reg    <= '0;
      Word_out     <= '0;
      Word_valid   <= 1'b0;
      Frame_err    <= 1'b0;
      All_zero     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      zero_cnt_reg <= zero_cnt_next;
      shift_reg    <= shift_next;
      Word_out     <= word_next;
      Word_valid   <= valid_next;
      Frame_err    <= err_next;
      All_zero     <= all_zero_next;
    end
  end

endmodule

// File: doc/msdap_frame_rx.md
Name: msdap_frame_rx

Overview:
Parametrised serial frame receiver for the MSDAP input path. Replaces the fixed 2-channel, 16-bit input capture and adds channel count, word width and bit order as parameters. Also adds frame-error detection and all-zero run detection, which feeds sleep-mode entry. Runs entirely in the SCLK domain and treats DCLK, Frame and serial data as asynchronous inputs that it synchronises and edge-detects.

Parameters:
NUM_CH, 2, number of serial data channels (L/R = 2)
WORD_W, 16, bits per frame word
SYNC_STAGES, 2, synchroniser depth for DCLK/Frame/Din (min 2)
ZERO_RUN, 800, consecutive all-zero words before All_zero asserts
MSB_FIRST, 1, 1 = first bit is MSB; 0 = first bit is LSB

Ports:
SCLK  in  1  system clock
Reset_n  in  1  reset; asynchronous assert, active-low
DCLK  in  1  data clock, asynchronous to SCLK, slower than SCLK/4
Frame  in  1  high with first bit of each word
Din  in  NUM_CH  serial data, bit c = channel c
Enable  in  1  receive enable (InReady from controller)
Word_out  out  NUM_CH*WORD_W  last complete words; channel c at [c*WORD_W +: WORD_W]
Word_valid  out  1  one-SCLK pulse, Word_out updated this cycle
Frame_err  out  1  one-SCLK pulse, Frame seen mid-word
All_zero  out  1  level, ZERO_RUN consecutive all-channel-zero words received
Busy  out  1  high while a word is partially received

Behaviour:
- Reset (Reset_n low, async): all synchroniser flops, shift registers and counters go to 0. State = IDLE. Word_out=0, Word_valid=0, Frame_err=0, All_zero=0, Busy=0.
- Synchroniser: DCLK, Frame and Din each pass through SYNC_STAGES flops. One extra flop on synced DCLK gives rising-edge detect. strobe = 1 SCLK cycle per DCLK rise.
- Frame and Din are sampled at the strobe from the same synchroniser stage, so their alignment is preserved.
- States and transitions:
  - IDLE, strobe & Frame: load bit, bit_cnt=1, go RECV.
  - IDLE, strobe & !Frame: ignore.
  - RECV, strobe & !Frame: shift bit in, bit_cnt++.
  - RECV, strobe & Frame & bit_cnt<WORD_W: pulse Frame_err, discard the partial word, restart with this bit as the first bit, bit_cnt=1.
  - RECV, bit_cnt reaches WORD_W on a strobe: next cycle Word_out <= shift regs, Word_valid pulses 1 cycle, go IDLE.
- Bit order: MSB_FIRST=1 shifts left, new bit into LSB. MSB_FIRST=0 shifts right, new bit into MSB. In both cases a completed word is in natural bit order.
- WORD_W=1: Frame on every bit. Each strobe with Frame completes a word. No Frame_err is possible.
- Latency: Word_valid rises SYNC_STAGES+2 SCLK cycles after the SCLK edge that first samples DCLK high for the last bit.
- Enable low: force IDLE and clear bit_cnt. Partial word discarded silently, no Frame_err. Word_out, zero counter and All_zero hold.
- Zero run:
  - On each Word_valid, if every channel word is 0, zero_cnt++, saturating at ZERO_RUN. Otherwise zero_cnt=0.
  - All_zero = (zero_cnt==ZERO_RUN), registered. It rises in the cycle Word_valid of the ZERO_RUN-th zero word is high.
  - All_zero clears in the cycle Word_valid of the first non-zero word is high.
- Counter widths: bit_cnt is $clog2(WORD_W+1); zero_cnt is $clog2(ZERO_RUN+1).
- Busy = (state==RECV).
- Word_out holds between valid pulses.

Decomposition:
- Package msdap_pkg holds rx_state_e {RX_IDLE, RX_RECV}, the default constants (MSDAP_WORD_W=16, MSDAP_NUM_CH=2, MSDAP_ZERO_RUN=800) and a clog2-based width helper.
- Sub-module msdap_sync_edge: parametrised SYNC_STAGES synchroniser for a bus, plus rising-edge detect output. It is instantiated once for the {DCLK, Frame, Din} bus.

Test Plan:
- Defaults, send ch0=0xA5C3 and ch1=0x1234 MSB-first with Frame on bit 15 -> one Word_valid, Word_out=0x1234_A5C3, Frame_err=0, Busy falls the same cycle.
- MSB_FIRST=0, WORD_W=24, NUM_CH=4, send 0x00ABCD LSB-first on all channels -> Word_out = four copies of 0x00ABCD.
- Frame reasserted after 7 bits, then a full 0xFFFF word -> Frame_err pulses once, Word_out=0xFFFF_FFFF, exactly one Word_valid.
- ZERO_RUN=4, send 4 all-zero words then ch0=0x0001 -> All_zero rises with the 4th Word_valid and falls with the 5th. A 3-zero run then non-zero never asserts it.
- Enable dropped after 10 bits, then raised and a full 0x5555 word sent -> no Frame_err, one Word_valid, Word_out=0x5555_5555.
- Reset_n pulsed low mid-word for 10 ns (async, between SCLK edges) -> all outputs 0 immediately. The next full word 0x8001 is received correctly.
